tetris_key_ctrl: RTL

- Parametrised keyboard-to-game-control front end. Sits between the PS/2 `keyboard` decoder (11-bit key_event) and the player logic.
- Maps NUM_KEYS scan codes to per-key held levels, press/release pulses and auto-repeat action pulses (DAS/ARR).
- Replaces ad-hoc single-pulse decoding with proper event edge detection and held-key tracking.

---
 rtl/tetris_key_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/tetris_key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tetris_key_ctrl
//  Description : Keyboard-to-game-control front end. Turns accepted PS/2 key
//                events into per-key held levels, press/release pulses and
//                auto-repeat action pulses (DAS delay, then ARR period).
//  Ports       : clk          system clock
//                rstn         synchronous active-low reset
//                key_event    [10] valid, [9] E0-ext, [8] break, [7:0] code
//                en           game input enable; 0 drops every key to idle
//                key_held     level, key i currently held
//                key_press    1-cycle pulse on make of key i
//                key_release  1-cycle pulse on break of key i
//                key_action   1-cycle pulse on press and on each repeat
//                unmapped_valid / unmapped_code {break, ext, code}
//                             only when TETRIS_KEY_UNMAPPED_EN is defined
//  Options     : `define TETRIS_KEY_UNMAPPED_EN to report unmatched events
//  Revision    : 1.0  initial release
// ============================================================================
module tetris_key_ctrl #(
    parameter int                    NUM_KEYS    = 8,
    parameter logic [9*NUM_KEYS-1:0] KEYMAP      = {9'h174, 9'h172, 9'h16B, 9'h175,
                                                    9'h023, 9'h01B, 9'h01C, 9'h01D},
    parameter logic [NUM_KEYS-1:0]   REPEAT_MASK = 8'hEE,
    parameter int                    DAS_CYCLES  = 17000000,
    parameter int                    ARR_CYCLES  = 5000000,
    parameter int                    CNT_W       = 25
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [10:0]         key_event,
    input  logic                en,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_action
`ifdef TETRIS_KEY_UNMAPPED_EN
    ,
    output logic                unmapped_valid,
    output logic [9:0]          unmapped_code
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_DELAY  = 2'd2,
        ST_REPEAT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_das_last = CNT_W'(DAS_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_arr_last = CNT_W'(ARR_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    // Resets high so a valid level already present at reset release is not
    // mistaken for a fresh rising edge.
    logic                r_prev_valid;
    logic                w_accept;
    logic [NUM_KEYS-1:0] w_sel;
    logic                w_any_match;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_prev_valid <= 1'b1;
        end else begin
            r_prev_valid <= key_event[10];
        end
    end

    assign w_accept = key_event[10] & ~r_prev_valid;

    // One-hot select of the matching key; the first hit blocks later
    // indices so duplicate map entries resolve to the lowest index.
    always_comb begin
        w_sel       = '0;
        w_any_match = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (!w_any_match && w_accept &&
                ({key_event[9], key_event[7:0]} == KEYMAP[9*i +: 9])) begin
                w_sel[i]    = 1'b1;
                w_any_match = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        state_t           r_state;
        state_t           w_nxt_state;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_nxt_cnt;
        logic             r_held;
        logic             r_press;
        logic             r_release;
        logic             r_action;
        logic             w_press;
        logic             w_release;
        logic             w_action;
        logic             w_make_hit;
        logic             w_brk_hit;

        assign w_make_hit = w_sel[i] & ~key_event[8];
        assign w_brk_hit  = w_sel[i] &  key_event[8];

        // Makes seen outside IDLE are keyboard typematic and are ignored;
        // a break checked before counter expiry gives break priority.
        always_comb begin
            w_nxt_state = r_state;
            w_nxt_cnt   = r_cnt;
            w_press     = 1'b0;
            w_release   = 1'b0;
            w_action    = 1'b0;
            if (!en) begin
                w_nxt_state = ST_IDLE;
                w_nxt_cnt   = '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_make_hit) begin
                            w_press     = 1'b1;
                            w_action    = 1'b1;
                            w_nxt_cnt   = '0;
                            w_nxt_state = REPEAT_MASK[i] ? ST_DELAY : ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (w_brk_hit) begin
                            w_release   = 1'b1;
                            w_nxt_state = ST_IDLE;
                        end
                    end
                    ST_DELAY: begin
                        if (w_brk_hit) begin
                            w_release   = 1'b1;
                            w_nxt_cnt   = '0;
                            w_nxt_state = ST_IDLE;
                        end else if (r_cnt == c_das_last) begin
                            w_action    = 1'b1;
                            w_nxt_cnt   = '0;
                            w_nxt_state = ST_REPEAT;
                        end else begin
                            w_nxt_cnt   = r_cnt + c_cnt_one;
                        end
                    end
                    ST_REPEAT: begin
                        if (w_brk_hit) begin
                            w_release   = 1'b1;
                            w_nxt_cnt   = '0;
                            w_nxt_state = ST_IDLE;
                        end else if (r_cnt == c_arr_last) begin
                            w_action    = 1'b1;
                            w_nxt_cnt   = '0;
                        end else begin
                            w_nxt_cnt   = r_cnt + c_cnt_one;
                        end
                    end
                    default: begin
                        w_nxt_state = ST_IDLE;
                        w_nxt_cnt   = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (!rstn) begin
                r_state   <= ST_IDLE;
                r_cnt     <= '0;
                r_held    <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_action  <= 1'b0;
            end else begin
                r_state   <= w_nxt_state;
                r_cnt     <= w_nxt_cnt;
                r_held    <= (w_nxt_state != ST_IDLE);
                r_press   <= w_press;
                r_release <= w_release;
                r_action  <= w_action;
            end
        end

        assign key_held[i]    = r_held;
        assign key_press[i]   = r_press;
        assign key_release[i] = r_release;
        assign key_action[i]  = r_action;
    end

`ifdef TETRIS_KEY_UNMAPPED_EN
    // Reported regardless of en so menu keys work while the game is paused.
    logic       r_unm_valid;
    logic [9:0] r_unm_code;
    logic       w_unm_hit;

    assign w_unm_hit = w_accept & ~w_any_match;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_unm_valid <= 1'b0;
            r_unm_code  <= '0;
        end else begin
            r_unm_valid <= w_unm_hit;
            if (w_unm_hit) begin
                r_unm_code <= {key_event[8], key_event[9], key_event[7:0]};
            end
        end
    end

    assign unmapped_valid = r_unm_valid;
    assign unmapped_code  = r_unm_code;
`else
    // Unmatched events are dropped: nothing selects them.
`endif

endmodule
`default_nettype wire
